// File: rtl/tetris_playfield_ctrl.sv
// Tetris playfield controller: board matrix, one falling piece,
// row clear with timed flash, saturating score and game-over.
module tetris_playfield_ctrl #(
   parameter int COLS           = 10,
   parameter int ROWS           = 20,
   parameter int GRAVITY_CYCLES = 50000000,
   parameter int FLASH_CYCLES   = 25000000,
   parameter int SCORE_W        = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   key_valid,
   input  logic [1:0]             key_code,
   output logic                   piece_req,
   input  logic                   piece_valid,
   input  logic [15:0]            piece_mask,
   output logic [ROWS*COLS-1:0]   objects,
   output logic [ROWS*COLS-1:0]   flash,
   output logic [SCORE_W-1:0]     score,
   output logic                   game_over
);

   localparam int N   = ROWS * COLS;
   localparam int IW  = $clog2(N);
   localparam int RIW = $clog2(ROWS);
   localparam int RW  = $clog2(ROWS) + 1;
   localparam int CW  = $clog2(COLS) + 2;
   localparam int GW  = $clog2(GRAVITY_CYCLES);
   localparam int FW  = $clog2(FLASH_CYCLES + 1);
   localparam logic signed [CW-1:0] SPAWN_COL = CW'(COLS / 2 - 2);

   typedef enum logic [3:0] {
      S_IDLE, S_SPAWN, S_FALL, S_DROP, S_LOCK,
      S_CHECK, S_FLASH, S_COLLAPSE, S_OVER
   } state_t;

   state_t                 state_q, state_d;
   logic [N-1:0]           board_q, board_d;
   logic [N-1:0]           flash_q, flash_d;
   logic [N-1:0]           objects_q, objects_d;
   logic [RW-1:0]          row_q, row_d;
   logic signed [CW-1:0]   col_q, col_d;
   logic [15:0]            mask_q, mask_d;
   logic [GW-1:0]          grav_q, grav_d;
   logic [FW-1:0]          fcnt_q, fcnt_d;
   logic [SCORE_W-1:0]     score_q, score_d;

   logic                   term;
   logic                   key_move;
   logic [N-1:0]           cur;
   logic [ROWS-1:0]        full_v;
   logic [ROWS-1:0]        rest_v;
   int                     fr;
   int                     r_i;
   int                     c_i;

   function automatic logic [N-1:0] cells_of(input int r, input int c,
                                             input logic [15:0] m);
      logic [N-1:0] v;
      v = '0;
      for (int pr = 0; pr < 4; pr++)
         for (int pc = 0; pc < 4; pc++)
            if (m[4'(4*pr+pc)] && r+pr < ROWS && c+pc >= 0 && c+pc < COLS)
               v[IW'((r+pr)*COLS+c+pc)] = 1'b1;
      return v;
   endfunction

   // Walls and floor count as occupied; rows never go negative.
   function automatic logic hits(input logic [N-1:0] b, input int r,
                                 input int c, input logic [15:0] m);
      logic h;
      h = 1'b0;
      for (int pr = 0; pr < 4; pr++)
         for (int pc = 0; pc < 4; pc++)
            if (m[4'(4*pr+pc)]) begin
               if (c+pc < 0 || c+pc >= COLS || r+pr >= ROWS)
                  h = 1'b1;
               else if (b[IW'((r+pr)*COLS+c+pc)])
                  h = 1'b1;
            end
      return h;
   endfunction

   function automatic logic [ROWS-1:0] full_rows(input logic [N-1:0] b);
      logic [ROWS-1:0] f;
      f = '1;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (!b[IW'(r*COLS+c)]) f[RIW'(r)] = 1'b0;
      return f;
   endfunction

   function automatic int bottom_full(input logic [ROWS-1:0] f);
      int k;
      k = 0;
      for (int r = 0; r < ROWS; r++)
         if (f[RIW'(r)]) k = r;
      return k;
   endfunction

   function automatic logic [N-1:0] expand(input logic [ROWS-1:0] f);
      logic [N-1:0] v;
      v = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            v[IW'(r*COLS+c)] = f[RIW'(r)];
      return v;
   endfunction

   function automatic logic [N-1:0] collapse(input logic [N-1:0] b,
                                             input int k);
      logic [N-1:0] v;
      v = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (r > k)
               v[IW'(r*COLS+c)] = b[IW'(r*COLS+c)];
            else if (r > 0)
               v[IW'(r*COLS+c)] = b[IW'((r-1)*COLS+c)];
      return v;
   endfunction

   always_comb begin
      r_i      = int'(row_q);
      c_i      = int'(col_q);
      cur      = cells_of(r_i, c_i, mask_q);
      full_v   = full_rows(board_q);
      fr       = bottom_full(full_v);
      rest_v   = full_v & ~(ROWS'(1) << fr);
      term     = (grav_q == GW'(GRAVITY_CYCLES - 1));
      key_move = key_valid && (key_code != 2'b11);

      state_d  = state_q;
      board_d  = board_q;
      flash_d  = flash_q;
      row_d    = row_q;
      col_d    = col_q;
      mask_d   = mask_q;
      grav_d   = grav_q;
      fcnt_d   = fcnt_q;
      score_d  = score_q;
      objects_d = board_q;
      if (state_q == S_FALL || state_q == S_DROP)
         objects_d = board_q | cur;

      unique case (state_q)
         S_IDLE: begin
            if (key_valid && key_code == 2'b11) state_d = S_SPAWN;
         end
         S_SPAWN: begin
            if (piece_valid) begin
               mask_d = piece_mask;
               row_d  = '0;
               col_d  = SPAWN_COL;
               grav_d = '0;
               if (hits(board_q, 0, int'(SPAWN_COL), piece_mask))
                  state_d = S_OVER;
               else
                  state_d = S_FALL;
            end
         end
         S_FALL: begin
            // A key on the terminal count defers gravity by one cycle.
            if (key_move) begin
               grav_d = term ? grav_q : grav_q + 1'b1;
               case (key_code)
                  2'b00: state_d = S_DROP;
                  2'b01: if (!hits(board_q, r_i, c_i - 1, mask_q))
                            col_d = col_q - 1'b1;
                  2'b10: if (!hits(board_q, r_i, c_i + 1, mask_q))
                            col_d = col_q + 1'b1;
                  default: ;
               endcase
            end else if (term) begin
               grav_d = '0;
               if (hits(board_q, r_i + 1, c_i, mask_q)) state_d = S_LOCK;
               else row_d = row_q + 1'b1;
            end else begin
               grav_d = grav_q + 1'b1;
            end
         end
         S_DROP: begin
            if (hits(board_q, r_i + 1, c_i, mask_q)) state_d = S_LOCK;
            else row_d = row_q + 1'b1;
         end
         S_LOCK: begin
            board_d = board_q | cur;
            mask_d  = '0;
            state_d = S_CHECK;
         end
         S_CHECK: begin
            if (|full_v) begin
               flash_d = expand(full_v);
               fcnt_d  = '0;
               state_d = S_FLASH;
            end else begin
               state_d = S_SPAWN;
            end
         end
         S_FLASH: begin
            if (fcnt_q == FW'(FLASH_CYCLES - 1)) begin
               flash_d = '0;
               state_d = S_COLLAPSE;
            end else begin
               fcnt_d = fcnt_q + 1'b1;
            end
         end
         S_COLLAPSE: begin
            if (|full_v) begin
               board_d = collapse(board_q, fr);
               if (score_q != '1) score_d = score_q + 1'b1;
               state_d = (|rest_v) ? S_COLLAPSE : S_SPAWN;
            end else begin
               state_d = S_SPAWN;
            end
         end
         S_OVER: begin
            if (key_valid && key_code == 2'b11) begin
               board_d = '0;
               score_d = '0;
               state_d = S_SPAWN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         board_q   <= '0;
         flash_q   <= '0;
         objects_q <= '0;
         row_q     <= '0;
         col_q     <= SPAWN_COL;
         mask_q    <= '0;
         grav_q    <= '0;
         fcnt_q    <= '0;
         score_q   <= '0;
      end else begin
         state_q   <= state_d;
         board_q   <= board_d;
         flash_q   <= flash_d;
         objects_q <= objects_d;
         row_q     <= row_d;
         col_q     <= col_d;
         mask_q    <= mask_d;
         grav_q    <= grav_d;
         fcnt_q    <= fcnt_d;
         score_q   <= score_d;
      end
   end

   assign objects   = objects_q;
   assign flash     = flash_q;
   assign score     = score_q;
   assign game_over = (state_q == S_OVER);
   assign piece_req = (state_q == S_SPAWN);

endmodule

// File: tb/tb_tetris_playfield_ctrl.sv
// Directed bench for tetris_playfield_ctrl on a 6x8 field with
// short gravity/flash timers and a 3-bit score.
module tb_tetris_playfield_ctrl;

   localparam logic [47:0] ROW7  = 48'hFC00_0000_0000;
   localparam logic [47:0] ROW67 = 48'hFFF0_0000_0000;

   logic        clk;
   logic        rst;
   logic        key_valid;
   logic [1:0]  key_code;
   logic        piece_req;
   logic        piece_valid;
   logic [15:0] piece_mask;
   logic [47:0] objects;
   logic [47:0] flash;
   logic [2:0]  score;
   logic        game_over;

   int tests = 0;
   int fails = 0;

   tetris_playfield_ctrl #(
      .COLS(6), .ROWS(8), .GRAVITY_CYCLES(4),
      .FLASH_CYCLES(3), .SCORE_W(3)
   ) dut (
      .clk(clk), .rst(rst),
      .key_valid(key_valid), .key_code(key_code),
      .piece_req(piece_req), .piece_valid(piece_valid),
      .piece_mask(piece_mask), .objects(objects),
      .flash(flash), .score(score), .game_over(game_over)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step(input logic v, input logic [1:0] c);
      key_valid = v;
      key_code  = c;
      tick();
      key_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      key_valid = 1'b0;
      key_code = 2'b00;
      piece_valid = 1'b0;
      piece_mask = '0;
      repeat (2) tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic give_piece(input logic [15:0] m);
      int i;
      i = 0;
      while (!piece_req && i < 60) begin
         tick();
         i++;
      end
      tests++;
      if (piece_req !== 1'b1) begin
         fails++;
         $display("FAIL piece_req_wait: got %b want 1", piece_req);
      end
      piece_valid = 1'b1;
      piece_mask  = m;
      tick();
      piece_valid = 1'b0;
   endtask

   task automatic drop_piece(input logic [15:0] m, input logic [1:0] c,
                             input int n);
      give_piece(m);
      repeat (n) step(1'b1, c);
      step(1'b1, 2'b00);
   endtask

   task automatic wait_flash();
      int i;
      i = 0;
      while (flash == '0 && i < 60) begin
         tick();
         i++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      key_valid = 1'b0;
      key_code = 2'b00;
      piece_valid = 1'b0;
      piece_mask = '0;
      #3;
      tests++;
      if (objects !== '0) begin
         fails++;
         $display("FAIL rst_objects: got %h want 0", objects);
      end
      tests++;
      if (flash !== '0) begin
         fails++;
         $display("FAIL rst_flash: got %h want 0", flash);
      end
      tests++;
      if ({score, game_over, piece_req} !== 5'b0) begin
         fails++;
         $display("FAIL rst_ctrl: score=%0d go=%b req=%b want 0",
                  score, game_over, piece_req);
      end
      tick();
   endtask

   task automatic test_spawn_gravity();
      do_reset();
      step(1'b1, 2'b01);
      tests++;
      if (piece_req !== 1'b0) begin
         fails++;
         $display("FAIL idle_key: piece_req got %b want 0", piece_req);
      end
      step(1'b1, 2'b11);
      tests++;
      if (piece_req !== 1'b1) begin
         fails++;
         $display("FAIL enter_req: piece_req got %b want 1", piece_req);
      end
      give_piece(16'h000F);
      tests++;
      if (piece_req !== 1'b0) begin
         fails++;
         $display("FAIL req_drop: piece_req got %b want 0", piece_req);
      end
      tick();
      tests++;
      if (objects !== 48'h1E) begin
         fails++;
         $display("FAIL spawn_pos: got %h want 1e", objects);
      end
      repeat (3) tick();
      tests++;
      if (objects !== 48'h1E) begin
         fails++;
         $display("FAIL grav_hold: got %h want 1e", objects);
      end
      tick();
      tests++;
      if (objects !== 48'h780) begin
         fails++;
         $display("FAIL grav_step: got %h want 780", objects);
      end
   endtask

   task automatic test_moves();
      do_reset();
      step(1'b1, 2'b11);
      give_piece(16'h000F);
      step(1'b1, 2'b01);
      step(1'b1, 2'b01);
      step(1'b0, 2'b00);
      tests++;
      if (objects !== 48'h0F) begin
         fails++;
         $display("FAIL left_wall: got %h want 0f", objects);
      end
      step(1'b1, 2'b10);
      step(1'b1, 2'b10);
      tests++;
      if (objects !== 48'h1E) begin
         fails++;
         $display("FAIL right_on_term: got %h want 1e", objects);
      end
      step(1'b1, 2'b10);
      step(1'b0, 2'b00);
      tests++;
      if (objects !== 48'h3C) begin
         fails++;
         $display("FAIL right_wall: got %h want 3c", objects);
      end
      step(1'b0, 2'b00);
      tests++;
      if (objects !== 48'hF00) begin
         fails++;
         $display("FAIL deferred_grav: got %h want f00", objects);
      end
   endtask

   task automatic test_row_clear();
      int n;
      do_reset();
      step(1'b1, 2'b11);
      drop_piece(16'h0011, 2'b01, 1);
      drop_piece(16'h0001, 2'b10, 4);
      give_piece(16'h0000);
      do_reset();
      step(1'b1, 2'b11);
      drop_piece(16'h0011, 2'b01, 1);
      drop_piece(16'h0001, 2'b10, 4);
      n = 0;
      while (!piece_req && n < 60) begin
         tick();
         n++;
      end
      tests++;
      if (objects !== 48'h8410_0000_0000) begin
         fails++;
         $display("FAIL preload: got %h want 841000000000", objects);
      end
      drop_piece(16'h000F, 2'b00, 0);
      wait_flash();
      tests++;
      if (flash !== ROW7) begin
         fails++;
         $display("FAIL flash_row7: got %h want %h", flash, ROW7);
      end
      n = 0;
      while (flash != '0 && n < 10) begin
         n++;
         tick();
      end
      tests++;
      if (n != 3) begin
         fails++;
         $display("FAIL flash_len: got %0d want 3", n);
      end
      tick();
      tests++;
      if (score !== 3'd1 || piece_req !== 1'b1) begin
         fails++;
         $display("FAIL clear1: score=%0d req=%b want 1 1",
                  score, piece_req);
      end
      tick();
      tests++;
      if (objects !== 48'h0400_0000_0000) begin
         fails++;
         $display("FAIL shift: got %h want 040000000000", objects);
      end
   endtask

   task automatic test_double_clear();
      int s;
      int e1;
      int e2;
      int n;
      do_reset();
      step(1'b1, 2'b11);
      s = 0;
      for (int k = 0; k < 4; k++) begin
         e1 = (s + 1 > 7) ? 7 : s + 1;
         e2 = (s + 2 > 7) ? 7 : s + 2;
         drop_piece(16'h0011, 2'b01, 1);
         drop_piece(16'h0011, 2'b10, 4);
         drop_piece(16'h00FF, 2'b00, 0);
         wait_flash();
         tests++;
         if (flash !== ROW67) begin
            fails++;
            $display("FAIL flash_rows67 %0d: got %h want %h",
                     k, flash, ROW67);
         end
         n = 0;
         while (flash != '0 && n < 10) begin
            n++;
            tick();
         end
         tick();
         tests++;
         if (score !== 3'(e1) || piece_req !== 1'b0) begin
            fails++;
            $display("FAIL collapse1 %0d: score=%0d req=%b want %0d 0",
                     k, score, piece_req, e1);
         end
         tick();
         tests++;
         if (score !== 3'(e2) || piece_req !== 1'b1) begin
            fails++;
            $display("FAIL collapse2 %0d: score=%0d req=%b want %0d 1",
                     k, score, piece_req, e2);
         end
         tick();
         tests++;
         if (objects !== '0) begin
            fails++;
            $display("FAIL board_empty %0d: got %h want 0", k, objects);
         end
         s = e2;
      end
   endtask

   task automatic test_game_over();
      logic [47:0] exp;
      do_reset();
      step(1'b1, 2'b11);
      repeat (4) drop_piece(16'h00FF, 2'b00, 0);
      give_piece(16'h000F);
      tests++;
      if (game_over !== 1'b1) begin
         fails++;
         $display("FAIL over: game_over got %b want 1", game_over);
      end
      exp = '0;
      for (int r = 0; r < 8; r++) exp = exp | (48'h1E << (6 * r));
      step(1'b1, 2'b00);
      step(1'b1, 2'b01);
      step(1'b1, 2'b10);
      tick();
      tests++;
      if (objects !== exp) begin
         fails++;
         $display("FAIL over_frozen: got %h want %h", objects, exp);
      end
      tests++;
      if (game_over !== 1'b1 || piece_req !== 1'b0) begin
         fails++;
         $display("FAIL over_keys: go=%b req=%b want 1 0",
                  game_over, piece_req);
      end
      step(1'b1, 2'b11);
      tests++;
      if (game_over !== 1'b0 || piece_req !== 1'b1 || score !== 3'd0) begin
         fails++;
         $display("FAIL restart: go=%b req=%b score=%0d want 0 1 0",
                  game_over, piece_req, score);
      end
      tick();
      tests++;
      if (objects !== '0) begin
         fails++;
         $display("FAIL restart_board: got %h want 0", objects);
      end
   endtask

   task automatic test_reset_mid_flash();
      do_reset();
      step(1'b1, 2'b11);
      drop_piece(16'h0001, 2'b01, 1);
      drop_piece(16'h0001, 2'b10, 4);
      drop_piece(16'h000F, 2'b00, 0);
      wait_flash();
      tests++;
      if (flash !== ROW7) begin
         fails++;
         $display("FAIL pre_rst_flash: got %h want %h", flash, ROW7);
      end
      tick();
      #2 rst = 1'b0;
      #1;
      tests++;
      if (flash !== '0 || objects !== '0) begin
         fails++;
         $display("FAIL async_rst: flash=%h obj=%h want 0 0",
                  flash, objects);
      end
      tests++;
      if ({score, game_over, piece_req} !== 5'b0) begin
         fails++;
         $display("FAIL async_rst_ctrl: score=%0d go=%b req=%b want 0",
                  score, game_over, piece_req);
      end
      #2 rst = 1'b1;
      tick();
      step(1'b1, 2'b00);
      repeat (3) tick();
      tests++;
      if (piece_req !== 1'b0 || objects !== '0) begin
         fails++;
         $display("FAIL idle_after_rst: req=%b obj=%h want 0 0",
                  piece_req, objects);
      end
      step(1'b1, 2'b11);
      tests++;
      if (piece_req !== 1'b1) begin
         fails++;
         $display("FAIL enter_after_rst: req=%b want 1", piece_req);
      end
   endtask

   initial begin
      test_reset();
      test_spawn_gravity();
      test_moves();
      test_row_clear();
      test_double_clear();
      test_game_over();
      test_reset_mid_flash();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
